// File: rtl/partition_op_issuer.sv
// partition_op_issuer: sequences PNEW/PSPLIT/PMERGE instructions into a
// partition_core operand interface, waits for completion and emits one
// trace record per instruction on a valid/ready stream.
module partition_op_issuer #(
    parameter int REGION_WIDTH   = 64,
    parameter int MU_WIDTH       = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [7:0]              instr_opcode,
    input  logic [REGION_WIDTH-1:0] instr_arg0,
    input  logic [7:0]              instr_arg1,
    input  logic [7:0]              instr_arg2,
    output logic [7:0]              core_op,
    output logic                    core_op_valid,
    output logic [REGION_WIDTH-1:0] core_pnew_region,
    output logic [REGION_WIDTH-1:0] core_psplit_mask,
    output logic [7:0]              core_psplit_module_id,
    output logic [7:0]              core_pmerge_m1,
    output logic [7:0]              core_pmerge_m2,
    input  logic                    core_op_done,
    input  logic [7:0]              core_num_modules,
    input  logic [MU_WIDTH-1:0]     core_mu_discovery,
    input  logic [MU_WIDTH-1:0]     core_mu_execution,
    input  logic [MU_WIDTH-1:0]     core_mu_cost,
    output logic                    trace_valid,
    input  logic                    trace_ready,
    output logic [31:0]             trace_step,
    output logic [7:0]              trace_opcode,
    output logic [REGION_WIDTH-1:0] trace_region,
    output logic [7:0]              trace_num_modules,
    output logic [MU_WIDTH-1:0]     trace_mu_discovery,
    output logic [MU_WIDTH-1:0]     trace_mu_execution,
    output logic [MU_WIDTH-1:0]     trace_mu_total,
    output logic [1:0]              trace_err,
    output logic                    busy
);

    // Counter is at least 8 bits wide, wider if the timeout needs it.
    localparam int CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW > 8) ? CNT_W_RAW : 8;

    localparam logic [7:0] OP_PNEW   = 8'h00;
    localparam logic [7:0] OP_PSPLIT = 8'h01;
    localparam logic [7:0] OP_PMERGE = 8'h02;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d, wait_cnt_inc;
    logic                    accept, legal, done_seen, timed_out, trace_hs;

    logic                    instr_ready_q, instr_ready_d;
    logic                    busy_q, busy_d;
    logic                    core_op_valid_q, core_op_valid_d;
    logic [7:0]              core_op_q, core_op_d;
    logic [REGION_WIDTH-1:0] pnew_region_q, pnew_region_d;
    logic [REGION_WIDTH-1:0] psplit_mask_q, psplit_mask_d;
    logic [7:0]              psplit_id_q, psplit_id_d;
    logic [7:0]              pmerge_m1_q, pmerge_m1_d;
    logic [7:0]              pmerge_m2_q, pmerge_m2_d;
    logic                    trace_valid_q, trace_valid_d;
    logic [31:0]             step_q, step_d;
    logic [7:0]              trace_opcode_q, trace_opcode_d;
    logic [REGION_WIDTH-1:0] trace_region_q, trace_region_d;
    logic [7:0]              trace_nm_q, trace_nm_d;
    logic [MU_WIDTH-1:0]     trace_mud_q, trace_mud_d;
    logic [MU_WIDTH-1:0]     trace_mue_q, trace_mue_d;
    logic [MU_WIDTH-1:0]     trace_mut_q, trace_mut_d;
    logic [1:0]              trace_err_q, trace_err_d;

    assign accept       = (state_q == S_IDLE) && instr_valid;
    assign legal        = (instr_opcode <= OP_PMERGE);
    assign wait_cnt_inc = wait_cnt_q + 1'b1;
    // wait_cnt_q == 0 marks the guard cycle, where done is not trusted.
    assign done_seen    = (state_q == S_WAIT) && (wait_cnt_q != '0) && core_op_done;
    assign timed_out    = (state_q == S_WAIT) && (wait_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    assign trace_hs     = (state_q == S_EMIT) && trace_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a completion wins over a timeout in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = legal ? S_ISSUE : S_EMIT;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (done_seen || timed_out) state_d = S_EMIT;
            S_EMIT:  if (trace_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; strobes are decoded from the next state so they come out of flops.
    always_comb begin
        instr_ready_d   = (state_d == S_IDLE);
        busy_d          = (state_d != S_IDLE);
        core_op_valid_d = (state_d == S_ISSUE);
        trace_valid_d   = (state_d == S_EMIT);
        wait_cnt_d      = wait_cnt_q;
        core_op_d       = core_op_q;
        pnew_region_d   = pnew_region_q;
        psplit_mask_d   = psplit_mask_q;
        psplit_id_d     = psplit_id_q;
        pmerge_m1_d     = pmerge_m1_q;
        pmerge_m2_d     = pmerge_m2_q;
        step_d          = step_q;
        trace_opcode_d  = trace_opcode_q;
        trace_region_d  = trace_region_q;
        trace_nm_d      = trace_nm_q;
        trace_mud_d     = trace_mud_q;
        trace_mue_d     = trace_mue_q;
        trace_mut_d     = trace_mut_q;
        trace_err_d     = trace_err_q;

        if (accept) begin
            trace_opcode_d = instr_opcode;
            trace_region_d = (instr_opcode == OP_PNEW || instr_opcode == OP_PSPLIT) ? instr_arg0 : '0;
            if (legal) begin
                // Operands hold until the next issue; fields the opcode does not use read as zero.
                core_op_d     = instr_opcode;
                pnew_region_d = (instr_opcode == OP_PNEW)   ? instr_arg0 : '0;
                psplit_mask_d = (instr_opcode == OP_PSPLIT) ? instr_arg0 : '0;
                psplit_id_d   = (instr_opcode == OP_PSPLIT) ? instr_arg1 : '0;
                pmerge_m1_d   = (instr_opcode == OP_PMERGE) ? instr_arg1 : '0;
                pmerge_m2_d   = (instr_opcode == OP_PMERGE) ? instr_arg2 : '0;
            end else begin
                trace_err_d = ERR_ILLEGAL;
                trace_nm_d  = '0;
                trace_mud_d = '0;
                trace_mue_d = '0;
                trace_mut_d = '0;
            end
        end

        if (state_q == S_ISSUE) wait_cnt_d = '0;
        if (state_q == S_WAIT)  wait_cnt_d = wait_cnt_inc;

        if (done_seen || timed_out) begin
            trace_err_d = done_seen ? ERR_OK : ERR_TIMEOUT;
            trace_nm_d  = core_num_modules;
            trace_mud_d = core_mu_discovery;
            trace_mue_d = core_mu_execution;
            trace_mut_d = core_mu_cost;
        end

        if (trace_hs) step_d = step_q + 32'd1;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_ready_q   <= 1'b1;
            busy_q          <= 1'b0;
            core_op_valid_q <= 1'b0;
            trace_valid_q   <= 1'b0;
            wait_cnt_q      <= '0;
            core_op_q       <= '0;
            pnew_region_q   <= '0;
            psplit_mask_q   <= '0;
            psplit_id_q     <= '0;
            pmerge_m1_q     <= '0;
            pmerge_m2_q     <= '0;
            step_q          <= '0;
            trace_opcode_q  <= '0;
            trace_region_q  <= '0;
            trace_nm_q      <= '0;
            trace_mud_q     <= '0;
            trace_mue_q     <= '0;
            trace_mut_q     <= '0;
            trace_err_q     <= '0;
        end else begin
            instr_ready_q   <= instr_ready_d;
            busy_q          <= busy_d;
            core_op_valid_q <= core_op_valid_d;
            trace_valid_q   <= trace_valid_d;
            wait_cnt_q      <= wait_cnt_d;
            core_op_q       <= core_op_d;
            pnew_region_q   <= pnew_region_d;
            psplit_mask_q   <= psplit_mask_d;
            psplit_id_q     <= psplit_id_d;
            pmerge_m1_q     <= pmerge_m1_d;
            pmerge_m2_q     <= pmerge_m2_d;
            step_q          <= step_d;
            trace_opcode_q  <= trace_opcode_d;
            trace_region_q  <= trace_region_d;
            trace_nm_q      <= trace_nm_d;
            trace_mud_q     <= trace_mud_d;
            trace_mue_q     <= trace_mue_d;
            trace_mut_q     <= trace_mut_d;
            trace_err_q     <= trace_err_d;
        end
    end

    assign instr_ready           = instr_ready_q;
    assign busy                  = busy_q;
    assign core_op_valid         = core_op_valid_q;
    assign core_op               = core_op_q;
    assign core_pnew_region      = pnew_region_q;
    assign core_psplit_mask      = psplit_mask_q;
    assign core_psplit_module_id = psplit_id_q;
    assign core_pmerge_m1        = pmerge_m1_q;
    assign core_pmerge_m2        = pmerge_m2_q;
    assign trace_valid           = trace_valid_q;
    assign trace_step            = step_q;
    assign trace_opcode          = trace_opcode_q;
    assign trace_region          = trace_region_q;
    assign trace_num_modules     = trace_nm_q;
    assign trace_mu_discovery    = trace_mud_q;
    assign trace_mu_execution    = trace_mue_q;
    assign trace_mu_total        = trace_mut_q;
    assign trace_err             = trace_err_q;

endmodule
